sseg_bcd_encoder: RTL and testbench

- Upstream feeder for the 4-digit seven-segment display multiplexer.
- Takes a 14-bit binary value and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Encodes each digit to a segment pattern, with leading-zero blanking and per-digit decimal points.
- seg3..seg0 connect directly to the multiplexer's in3..in0 and hold steady between updates.

---
 rtl/sseg_bcd_encoder_if.sv | 27 ++
 rtl/sseg_bcd_encoder.sv | 127 ++++++++++++
 tb/tb_sseg_bcd_encoder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sseg_bcd_encoder_if.sv
// Load/result bundle between a value producer and the seven-segment BCD encoder.
interface sseg_bcd_encoder_if #(
  parameter int unsigned BIN_W = 14
);
  logic             load;
  logic [BIN_W-1:0] bin;
  logic [3:0]       dp_sel;
  logic             blank_lz;
  logic             ready;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [7:0]       seg3;
  logic [7:0]       seg2;
  logic [7:0]       seg1;
  logic [7:0]       seg0;

  modport master (
    output load, bin, dp_sel, blank_lz,
    input  ready, busy, done, overflow, seg3, seg2, seg1, seg0
  );

  modport slave (
    input  load, bin, dp_sel, blank_lz,
    output ready, busy, done, overflow, seg3, seg2, seg1, seg0
  );
endinterface

// File: rtl/sseg_bcd_encoder.sv
// Binary-to-4-digit seven-segment encoder: sequential double-dabble conversion,
// then segment encoding with leading-zero blanking, decimal points and overflow dashes.
module sseg_bcd_encoder #(
  parameter int unsigned BIN_W   = 14,
  parameter int unsigned MAX_VAL = 9999
) (
  input  logic                clk,
  input  logic                rst_n,
  sseg_bcd_encoder_if.slave   bus
);

  localparam int unsigned BCD_W = 16;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, CONVERT, ENCODE} state_t;

  state_t             state;
  logic [BIN_W-1:0]   bin_sh;
  logic [BCD_W-1:0]   bcd;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         dp_r;
  logic               blz_r;
  logic               ovf_r;

  logic [BCD_W-1:0]       bcd_adj;
  logic [BCD_W+BIN_W-1:0] shift_w;
  logic [3:0]             blank;
  logic [7:0]             seg_c [4];

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd,bin} left.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      else                       bcd_adj[4*i +: 4] = bcd[4*i +: 4];
    end
    shift_w = {bcd_adj, bin_sh} << 1;
  end

  // Segment patterns from the finished BCD; a digit blanks only when all higher digits are zero.
  always_comb begin
    blank    = '0;
    blank[3] = blz_r && (bcd[15:12] == 4'd0);
    blank[2] = blank[3] && (bcd[11:8] == 4'd0);
    blank[1] = blank[2] && (bcd[7:4] == 4'd0);
    for (int k = 0; k < 4; k++) begin
      seg_c[k] = 8'h00;
      if (ovf_r)         seg_c[k] = {dp_r[k], 7'h40};
      else if (blank[k]) seg_c[k] = {dp_r[k], 7'h00};
      else               seg_c[k] = {dp_r[k], digit_seg(bcd[4*k +: 4])};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bin_sh       <= '0;
      bcd          <= '0;
      cnt          <= '0;
      dp_r         <= '0;
      blz_r        <= 1'b0;
      ovf_r        <= 1'b0;
      bus.ready    <= 1'b1;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.overflow <= 1'b0;
      bus.seg3     <= 8'h00;
      bus.seg2     <= 8'h00;
      bus.seg1     <= 8'h00;
      bus.seg0     <= 8'h00;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            bin_sh    <= bus.bin;
            dp_r      <= bus.dp_sel;
            blz_r     <= bus.blank_lz;
            ovf_r     <= bus.bin > BIN_W'(MAX_VAL);
            bcd       <= '0;
            cnt       <= '0;
            bus.ready <= 1'b0;
            bus.busy  <= 1'b1;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          bcd    <= shift_w[BCD_W+BIN_W-1 -: BCD_W];
          bin_sh <= shift_w[BIN_W-1:0];
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(BIN_W - 1)) state <= ENCODE;
        end
        ENCODE: begin
          bus.seg3     <= seg_c[3];
          bus.seg2     <= seg_c[2];
          bus.seg1     <= seg_c[1];
          bus.seg0     <= seg_c[0];
          bus.overflow <= ovf_r;
          bus.done     <= 1'b1;
          bus.ready    <= 1'b1;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sseg_bcd_encoder.sv
// Self-checking bench for sseg_bcd_encoder: directed cases plus random values
// checked against a decimal-arithmetic reference model.
module tb_sseg_bcd_encoder;

  localparam int unsigned BIN_W   = 14;
  localparam int unsigned LAT     = BIN_W + 1;
  localparam logic [6:0]  DIGIT_TBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  sseg_bcd_encoder_if #(.BIN_W(BIN_W)) bus ();

  sseg_bcd_encoder #(.BIN_W(BIN_W), .MAX_VAL(9999)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {seg3,seg2,seg1,seg0} from decimal digit arithmetic.
  function automatic logic [31:0] model(input int v, input logic [3:0] dp, input logic blz);
    logic [31:0] r;
    logic [6:0]  pat;
    int          p;
    r = '0;
    p = 1;
    for (int k = 0; k < 4; k++) begin
      if (v > 9999)                pat = 7'h40;
      else if (blz && k > 0 && v < p) pat = 7'h00;
      else                         pat = DIGIT_TBL[(v / p) % 10];
      r[8*k +: 8] = {dp[k], pat};
      p = p * 10;
    end
    return r;
  endfunction

  // Issue one load and follow it to the result; inj>0 pulses a stray load on that CONVERT cycle.
  task automatic run(input int v, input logic [3:0] dp, input logic blz, input int inj, input string tag);
    logic [31:0] exp_segs;
    int          guard;
    guard = 0;
    while (bus.ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_ready_before"}, 32'(bus.ready), 32'd1);
    bus.load     = 1'b1;
    bus.bin      = BIN_W'(v);
    bus.dp_sel   = dp;
    bus.blank_lz = blz;
    @(posedge clk); #1;
    bus.load = 1'b0;
    chk({tag, "_busy_accept"}, 32'(bus.busy), 32'd1);
    chk({tag, "_done_low_accept"}, 32'(bus.done), 32'd0);
    for (int c = 1; c <= int'(LAT); c++) begin
      @(negedge clk);
      if (c == inj) begin
        bus.load = 1'b1;
        bus.bin  = BIN_W'(5678);
      end else begin
        bus.load = 1'b0;
      end
      @(posedge clk); #1;
      if (c == int'(LAT) - 1) begin
        chk({tag, "_ready_low"}, 32'(bus.ready), 32'd0);
        chk({tag, "_done_early"}, 32'(bus.done), 32'd0);
      end
    end
    bus.load = 1'b0;
    exp_segs = model(v, dp, blz);
    chk({tag, "_done"},     32'(bus.done),     32'd1);
    chk({tag, "_ready"},    32'(bus.ready),    32'd1);
    chk({tag, "_segs"},     {bus.seg3, bus.seg2, bus.seg1, bus.seg0}, exp_segs);
    chk({tag, "_overflow"}, 32'(bus.overflow), 32'(v > 9999));
  endtask

  initial begin
    int          v;
    int          done_cnt;
    logic [3:0]  dp;
    logic        blz;

    bus.load     = 1'b0;
    bus.bin      = '0;
    bus.dp_sel   = '0;
    bus.blank_lz = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_segs",     {bus.seg3, bus.seg2, bus.seg1, bus.seg0}, 32'h0);
    chk("rst_ready",    32'(bus.ready),    32'd1);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_done",     32'(bus.done),     32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(1234, 4'b0000, 1'b0, 0, "v1234");
    chk("v1234_literal", {bus.seg3, bus.seg2, bus.seg1, bus.seg0}, 32'h065B4F66);
    @(posedge clk); #1;
    chk("v1234_done_one_cycle", 32'(bus.done), 32'd0);

    run(7, 4'b0000, 1'b1, 0, "v7_blz");
    chk("v7_blz_literal", {bus.seg3, bus.seg2, bus.seg1, bus.seg0}, 32'h00000007);
    run(7, 4'b0000, 1'b0, 0, "v7_noblz");
    chk("v7_noblz_literal", {bus.seg3, bus.seg2, bus.seg1, bus.seg0}, 32'h3F3F3F07);
    run(0, 4'b0010, 1'b1, 0, "v0_dp");
    chk("v0_dp_literal", {bus.seg3, bus.seg2, bus.seg1, bus.seg0}, 32'h0000803F);
    run(10000, 4'b0000, 1'b0, 0, "v10000");
    chk("v10000_literal", {bus.seg3, bus.seg2, bus.seg1, bus.seg0}, 32'h40404040);
    run(9999, 4'b0000, 1'b0, 0, "v9999");
    chk("v9999_literal", {bus.seg3, bus.seg2, bus.seg1, bus.seg0}, 32'h6F6F6F6F);
    run(16383, 4'b1010, 1'b1, 0, "vmax");

    // Stray load during conversion, then an immediate back-to-back load.
    run(1234, 4'b0000, 1'b0, 5, "busy_load");
    run(56, 4'b0100, 1'b1, 0, "back2back");

    for (int i = 0; i < 20; i++) begin
      case (i % 4)
        0:       v = int'($urandom_range(0, 99));
        1:       v = int'($urandom_range(0, 9999));
        2:       v = int'($urandom_range(9990, 10010));
        default: v = int'($urandom_range(0, 16383));
      endcase
      dp  = 4'($urandom_range(0, 15));
      blz = 1'($urandom_range(0, 1));
      run(v, dp, blz, 0, "rand");
    end

    // Reset mid-conversion aborts and clears everything.
    @(negedge clk);
    bus.load     = 1'b1;
    bus.bin      = BIN_W'(4321);
    bus.dp_sel   = 4'b1111;
    bus.blank_lz = 1'b0;
    @(posedge clk); #1;
    bus.load = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_segs",     {bus.seg3, bus.seg2, bus.seg1, bus.seg0}, 32'h0);
    chk("midrst_ready",    32'(bus.ready),    32'd1);
    chk("midrst_busy",     32'(bus.busy),     32'd0);
    chk("midrst_overflow", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) done_cnt++;
    end
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    chk("midrst_segs_hold", {bus.seg3, bus.seg2, bus.seg1, bus.seg0}, 32'h0);

    run(4321, 4'b0001, 1'b0, 0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
